pack_rx_fifo: RTL and testbench
===============================

Name: pack_rx_fifo

Overview:
Downstream of the receive-side packer. Buffers each packed multi-lane word, qualified by the packer's FIFO write strobe, into a first-word-fall-through FIFO. Drains the FIFO to the link layer as an AXI-Stream master with per-lane keep, K/sync-header sideband and ENDP-derived tlast. Flushes on link down and reports overflow.

Parameters:
DATA_WIDTH, 32, bits per lane word.
MAX_NUM_LANES, 4, lanes per packed word; W = MAX_NUM_LANES*DATA_WIDTH.
DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset, asynchronous, active-low.
phy_link_up_i  in  1  link up; low flushes the FIFO.
wr_en_i  in  1  write strobe (packer fifo_wr).
data_i  in  W  packed data.
data_valid_i  in  MAX_NUM_LANES  per-lane valid.
data_k_i  in  4*MAX_NUM_LANES  per-byte K flags.
sync_header_i  in  2*MAX_NUM_LANES  per-lane sync header.
m_axis_tdata  out  W  entry data.
m_axis_tkeep  out  MAX_NUM_LANES  entry data_valid.
m_axis_tuser  out  6*MAX_NUM_LANES  {sync_header, data_k}.
m_axis_tlast  out  1  entry contains ENDP.
m_axis_tvalid  out  1  FIFO not empty.
m_axis_tready  in  1  sink ready.
level_o  out  $clog2(DEPTH)+1  occupancy.
full_o  out  1  level_o == DEPTH.
overflow_o  out  1  sticky drop flag.
drop_cnt_o  out  16  dropped writes, saturating.
clr_status_i  in  1  clears overflow_o and drop_cnt_o.

Behaviour:
- Reset (rst_i low, async): pointers 0, level_o 0, m_axis_tvalid 0, full_o 0, overflow_o 0, drop_cnt_o 0. Memory contents are not reset. m_axis_tdata, m_axis_tkeep, m_axis_tuser and m_axis_tlast are don't-care while tvalid is 0.
- Storage: DEPTH entries, each {data, valid, k, sync, last}.
- last flag at write time: 1 if any byte j (0..W/8-1) has data_i[8j+:8] == ENDP and data_valid_i[j/(DATA_WIDTH/8)] == 1.
- Push: wr_en_i && phy_link_up_i && (!full_o || pop).
- Pop: m_axis_tvalid && m_axis_tready.
- FWFT: the head entry drives the m_axis_* outputs combinationally from the memory.
- Write latency: a push at edge N makes m_axis_tvalid high after edge N when the FIFO was empty. No same-cycle bypass.
- Push and pop together: pointers both advance and level_o is unchanged. When full, a push in the same cycle as a pop is accepted.
- Drop: wr_en_i && phy_link_up_i && full_o && !pop.
  - Entry is discarded; the FIFO is unchanged.
  - overflow_o sets at the next edge.
  - drop_cnt_o increments and saturates at 16'hFFFF.
- wr_en_i while phy_link_up_i is low: ignored; not counted as a drop.
- Link down (phy_link_up_i low, sampled): synchronous flush.
  - Pointers and level_o go to 0 at the next edge; m_axis_tvalid is low from then on.
  - A pop in the same cycle is allowed but has no further effect.
  - overflow_o and drop_cnt_o are kept.
- clr_status_i: clears overflow_o and drop_cnt_o at the next edge. If a drop occurs in the same cycle, the drop wins: overflow_o = 1, drop_cnt_o = 1.
- AXI-Stream rules:
  - tvalid is never withdrawn without a pop, except on flush or reset.
  - Head outputs are stable while tvalid && !tready.
- Pointers wrap modulo DEPTH and carry an extra wrap bit for full/empty detection. level_o = wr_ptr - rd_ptr, using the extended width.

Test Plan:
- Reset, then 3 pushes with m_axis_tready = 0 -> level_o = 3, tvalid = 1, tdata = first word. Raise tready -> 3 beats in write order, then tvalid = 0.
- Push a word with byte 5 = ENDP, data_valid = 4'b0011 -> tlast = 1. Push the same word with data_valid = 4'b0001 -> tlast = 0.
- Fill to DEPTH = 8 with tready = 0, then 2 more writes -> full_o = 1, overflow_o = 1, drop_cnt_o = 2, level_o = 8. Drain -> the 8 original words only.
- Full FIFO, wr_en_i and tready both high for 4 cycles -> no drops, level_o stays 8, output order preserved.
- 5 entries buffered, drop phy_link_up_i for 1 cycle -> level_o = 0 and tvalid = 0 next cycle; drop_cnt_o unchanged. Write during link down -> not stored, not counted.
- drop_cnt_o at 16'hFFFF plus another drop -> stays 16'hFFFF. clr_status_i together with a drop -> drop_cnt_o = 1, overflow_o = 1. Assert rst_i low mid-drain -> all outputs at reset values immediately, without a clock edge.

Source files
------------

// File: rtl/pack_rx_fifo.sv
// Receive-side FWFT buffer: packed lane words in, AXI-Stream beats out with keep/K/sync sideband and ENDP tlast.
// One edge from push to tvalid; tready stalls the head, a push into a full FIFO without a pop is dropped and counted.
module pack_rx_fifo #(
  parameter int          DATA_WIDTH    = 32,
  parameter int          MAX_NUM_LANES = 4,
  parameter int          DEPTH         = 8,
  parameter logic [7:0]  ENDP          = 8'hFD
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              phy_link_up_i,
  input  logic                              wr_en_i,
  input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
  input  logic [MAX_NUM_LANES-1:0]          data_valid_i,
  input  logic [4*MAX_NUM_LANES-1:0]        data_k_i,
  input  logic [2*MAX_NUM_LANES-1:0]        sync_header_i,
  output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [MAX_NUM_LANES-1:0]          m_axis_tkeep,
  output logic [6*MAX_NUM_LANES-1:0]        m_axis_tuser,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic [$clog2(DEPTH):0]            level_o,
  output logic                              full_o,
  output logic                              overflow_o,
  output logic [15:0]                       drop_cnt_o,
  input  logic                              clr_status_i
);

  localparam int W  = MAX_NUM_LANES * DATA_WIDTH;
  localparam int L  = MAX_NUM_LANES;
  localparam int AW = $clog2(DEPTH);
  localparam int BYTES_PER_LANE = DATA_WIDTH / 8;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [W-1:0]   data;
    logic [L-1:0]   valid;
    logic [4*L-1:0] k;
    logic [2*L-1:0] sync;
    logic           last;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        wr_entry_d;
  entry_t        head;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic          empty, full, pop, push, drop;

  // Extra wrap bit distinguishes full (MSBs differ) from empty (all equal).
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && m_axis_tready;
  assign push  = wr_en_i && phy_link_up_i && (!full || pop);
  assign drop  = wr_en_i && phy_link_up_i && full && !pop;

  always_comb begin
    wr_entry_d       = '0;
    wr_entry_d.data  = data_i;
    wr_entry_d.valid = data_valid_i;
    wr_entry_d.k     = data_k_i;
    wr_entry_d.sync  = sync_header_i;
    for (int j = 0; j < W/8; j++) begin
      if (data_i[8*j +: 8] == ENDP && data_valid_i[j / BYTES_PER_LANE])
        wr_entry_d.last = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (!phy_link_up_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    // A drop in the same cycle as a clear restarts the count at one.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_status_i)              drop_cnt_d = 16'd1;
      else if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end else if (clr_status_i) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry_d;
  end

  assign head          = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tdata  = head.data;
  assign m_axis_tkeep  = head.valid;
  assign m_axis_tuser  = {head.sync, head.k};
  assign m_axis_tlast  = head.last;
  assign m_axis_tvalid = !empty;
  assign level_o       = wr_ptr_q - rd_ptr_q;
  assign full_o        = full;
  assign overflow_o    = overflow_q;
  assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_pack_rx_fifo.sv
// Bench for pack_rx_fifo: directed steps plus random traffic, checked against a queue model.
module tb_pack_rx_fifo;
  localparam int DW = 32;
  localparam int NL = 4;
  localparam int DEPTH = 8;
  localparam int W = DW * NL;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           phy_link_up_i;
  logic           wr_en_i;
  logic [W-1:0]   data_i;
  logic [NL-1:0]  data_valid_i;
  logic [4*NL-1:0] data_k_i;
  logic [2*NL-1:0] sync_header_i;
  logic [W-1:0]   m_axis_tdata;
  logic [NL-1:0]  m_axis_tkeep;
  logic [6*NL-1:0] m_axis_tuser;
  logic           m_axis_tlast;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic [3:0]     level_o;
  logic           full_o;
  logic           overflow_o;
  logic [15:0]    drop_cnt_o;
  logic           clr_status_i;

  pack_rx_fifo #(.DATA_WIDTH(DW), .MAX_NUM_LANES(NL), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .phy_link_up_i(phy_link_up_i), .wr_en_i(wr_en_i),
    .data_i(data_i), .data_valid_i(data_valid_i), .data_k_i(data_k_i),
    .sync_header_i(sync_header_i), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .level_o(level_o), .full_o(full_o),
    .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o), .clr_status_i(clr_status_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [W-1:0]    d;
    logic [NL-1:0]   v;
    logic [4*NL-1:0] k;
    logic [2*NL-1:0] s;
  } ent_t;

  ent_t        q[$];
  logic        m_ovf;
  logic [15:0] m_cnt;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic logic exp_last(input logic [W-1:0] d, input logic [NL-1:0] v);
    logic r = 1'b0;
    for (int lane = 0; lane < NL; lane++)
      for (int b = 0; b < DW/8; b++)
        if (v[lane] && d[lane*DW + b*8 +: 8] == 8'hFD) r = 1'b1;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("tvalid", 128'(m_axis_tvalid), 128'(q.size() != 0));
    chk("level", 128'(level_o), 128'(q.size()));
    chk("full", 128'(full_o), 128'(q.size() == DEPTH));
    chk("overflow", 128'(overflow_o), 128'(m_ovf));
    chk("drop_cnt", 128'(drop_cnt_o), 128'(m_cnt));
    if (q.size() != 0) begin
      chk("tdata", 128'(m_axis_tdata), 128'(q[0].d));
      chk("tkeep", 128'(m_axis_tkeep), 128'(q[0].v));
      chk("tuser", 128'(m_axis_tuser), 128'({q[0].s, q[0].k}));
      chk("tlast", 128'(m_axis_tlast), 128'(exp_last(q[0].d, q[0].v)));
    end
  endtask

  // Advance one clock, applying the same edge to the model.
  task automatic step();
    logic pop, full, push, drop;
    ent_t e;
    pop  = (q.size() != 0) && m_axis_tready;
    full = (q.size() == DEPTH);
    push = wr_en_i && phy_link_up_i && (!full || pop);
    drop = wr_en_i && phy_link_up_i && full && !pop;
    e.d = data_i; e.v = data_valid_i; e.k = data_k_i; e.s = sync_header_i;
    @(posedge clk_i);
    if (pop) void'(q.pop_front());
    if (!phy_link_up_i) q.delete();
    else if (push) q.push_back(e);
    if (drop) begin
      m_ovf = 1'b1;
      if (clr_status_i) m_cnt = 16'd1;
      else if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end else if (clr_status_i) begin
      m_ovf = 1'b0;
      m_cnt = 16'd0;
    end
    #1;
  endtask

  task automatic rand_in();
    logic [W-1:0] d;
    d = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 2) == 0) d[8*$urandom_range(0, W/8-1) +: 8] = 8'hFD;
    data_i        = d;
    data_valid_i  = 4'($urandom);
    data_k_i      = 16'($urandom);
    sync_header_i = 8'($urandom);
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      rand_in();
      wr_en_i = 1'b1;
      step();
      check_all();
    end
    wr_en_i = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    m_axis_tready = 1'b1;
    wr_en_i = 1'b0;
    while (q.size() != 0 && guard < 50) begin
      step();
      check_all();
      guard++;
    end
    chk("drain_bound", 128'(q.size()), 128'(0));
  endtask

  initial begin
    logic [15:0] saved_cnt;
    rst_i = 1'b0; phy_link_up_i = 1'b1; wr_en_i = 1'b0; m_axis_tready = 1'b0;
    clr_status_i = 1'b0; data_i = '0; data_valid_i = '0; data_k_i = '0; sync_header_i = '0;
    m_ovf = 1'b0; m_cnt = 16'd0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all();
    rst_i = 1'b1;

    // Three pushes held, then drained in order.
    push_n(3);
    chk("level3", 128'(level_o), 128'(3));
    drain();
    chk("empty_after_drain", 128'(m_axis_tvalid), 128'(0));

    // ENDP in byte 5 counts only when its lane is valid.
    m_axis_tready = 1'b0;
    data_i = 128'h11111111_22222222_3333FD44_55555555;
    data_valid_i = 4'b0011; data_k_i = '0; sync_header_i = 8'h55;
    wr_en_i = 1'b1; step(); wr_en_i = 1'b0;
    check_all();
    chk("endp_lane1_valid", 128'(m_axis_tlast), 128'(1));
    drain();
    m_axis_tready = 1'b0;
    data_valid_i = 4'b0001;
    wr_en_i = 1'b1; step(); wr_en_i = 1'b0;
    check_all();
    chk("endp_lane1_invalid", 128'(m_axis_tlast), 128'(0));
    drain();

    // Overfill by two.
    m_axis_tready = 1'b0;
    push_n(DEPTH + 2);
    chk("ovf_full", 128'(full_o), 128'(1));
    chk("ovf_sticky", 128'(overflow_o), 128'(1));
    chk("ovf_cnt2", 128'(drop_cnt_o), 128'(2));
    chk("ovf_level8", 128'(level_o), 128'(8));
    drain();

    // Full with simultaneous push and pop.
    m_axis_tready = 1'b0;
    push_n(DEPTH);
    saved_cnt = drop_cnt_o;
    m_axis_tready = 1'b1;
    push_n(4);
    chk("pp_level8", 128'(level_o), 128'(8));
    chk("pp_no_drop", 128'(drop_cnt_o), 128'(saved_cnt));
    drain();

    // Link drop flushes; writes during link down are ignored.
    m_axis_tready = 1'b0;
    push_n(5);
    saved_cnt = drop_cnt_o;
    phy_link_up_i = 1'b0;
    rand_in(); wr_en_i = 1'b1;
    step(); check_all();
    chk("flush_level", 128'(level_o), 128'(0));
    chk("flush_tvalid", 128'(m_axis_tvalid), 128'(0));
    step(); check_all();
    phy_link_up_i = 1'b1; wr_en_i = 1'b0;
    step(); check_all();
    chk("linkdown_not_stored", 128'(level_o), 128'(0));
    chk("linkdown_not_counted", 128'(drop_cnt_o), 128'(saved_cnt));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rand_in();
      wr_en_i       = ($urandom_range(0, 3) != 0);
      m_axis_tready = $urandom_range(0, 1) == 1;
      phy_link_up_i = ($urandom_range(0, 29) != 0);
      clr_status_i  = ($urandom_range(0, 15) == 0);
      step();
      check_all();
    end
    phy_link_up_i = 1'b1; clr_status_i = 1'b0;
    drain();

    // Saturate the drop counter.
    m_axis_tready = 1'b0;
    push_n(DEPTH);
    wr_en_i = 1'b1;
    for (int i = 0; i < 65540; i++) step();
    check_all();
    chk("sat_ffff", 128'(drop_cnt_o), 128'(16'hFFFF));
    clr_status_i = 1'b1;
    step(); check_all();
    chk("clr_drop_cnt1", 128'(drop_cnt_o), 128'(1));
    chk("clr_drop_ovf1", 128'(overflow_o), 128'(1));
    wr_en_i = 1'b0;
    step(); check_all();
    chk("clr_only", 128'(drop_cnt_o), 128'(0));
    clr_status_i = 1'b0;
    wr_en_i = 1'b1;
    step(); check_all();
    wr_en_i = 1'b0;

    // Asynchronous reset in the middle of a drain.
    m_axis_tready = 1'b1;
    step(); check_all();
    step(); check_all();
    #2;
    rst_i = 1'b0;
    #1;
    q.delete(); m_ovf = 1'b0; m_cnt = 16'd0;
    chk("arst_tvalid", 128'(m_axis_tvalid), 128'(0));
    chk("arst_level", 128'(level_o), 128'(0));
    chk("arst_full", 128'(full_o), 128'(0));
    chk("arst_ovf", 128'(overflow_o), 128'(0));
    chk("arst_cnt", 128'(drop_cnt_o), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
